// File: rtl/hand_dealer_if.sv
// Request/response bundle between a card-dealing client and hand_dealer.
interface hand_dealer_if;
    logic       deal_req;
    logic       deal_to;
    logic       clear;
    logic [3:0] pcard1;
    logic [3:0] pcard2;
    logic [3:0] pcard3;
    logic [3:0] dcard1;
    logic [3:0] dcard2;
    logic [3:0] dcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic       busy;
    logic       deal_ack;
    logic       deal_err;

    // Client side: issues requests, observes hands and status.
    modport master (
        output deal_req, deal_to, clear,
        input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        input  pscore, dscore, busy, deal_ack, deal_err
    );

    // Dealer side.
    modport slave (
        input  deal_req, deal_to, clear,
        output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
        output pscore, dscore, busy, deal_ack, deal_err
    );
endinterface

// File: rtl/hand_dealer.sv
// Deals cards from a free-running 1..13 deck counter into a player or dealer
// hand of three slots and keeps a registered mod-10 score for each hand.
module hand_dealer (
    input  logic         clk,
    input  logic         resetb,
    hand_dealer_if.slave bus
);
    localparam int unsigned CW       = 4;   // card / score width
    localparam int unsigned SW       = 5;   // score sum width before modulo
    localparam int unsigned DECK_MAX = 13;

    typedef logic [2:0][CW-1:0] hand_t;
    typedef enum logic [1:0] {IDLE, LOAD, SCORE} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   deck_cnt;
    logic [CW-1:0]   card;
    logic            deal_dst;
    hand_t           pslot;
    hand_t           dslot;
    logic [CW-1:0]   pscore;
    logic [CW-1:0]   dscore;
    logic            busy_r;
    logic            ack_r;
    logic            err_r;

    logic            accept;
    logic            load_en;
    logic            score_en;
    logic            ack_next;
    logic            err_next;
    logic            busy_next;
    logic            target_full;

    // Scoring value: A..9 at face value, tens/faces and empty slots count 0.
    function automatic logic [CW-1:0] card_value(input logic [CW-1:0] c);
        return (c != '0 && c <= CW'(9)) ? c : '0;
    endfunction

    // Full-width sum of the three slot values, then reduced mod 10.
    function automatic logic [CW-1:0] hand_score(input hand_t h);
        logic [SW-1:0] sum;
        sum = SW'(card_value(h[0])) + SW'(card_value(h[1])) + SW'(card_value(h[2]));
        return CW'(sum % SW'(10));
    endfunction

    // Place a card into the lowest-numbered empty slot.
    function automatic hand_t insert_card(input hand_t h, input logic [CW-1:0] c);
        hand_t r;
        r = h;
        if (h[0] == '0)
            r[0] = c;
        else if (h[1] == '0)
            r[1] = c;
        else if (h[2] == '0)
            r[2] = c;
        return r;
    endfunction

    assign target_full = bus.deal_to ? (dslot[2] != '0) : (pslot[2] != '0);

    // Free-running deck counter, 1..13, independent of requests and clear.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            deck_cnt <= CW'(1);
        else if (deck_cnt == CW'(DECK_MAX))
            deck_cnt <= CW'(1);
        else
            deck_cnt <= deck_cnt + CW'(1);
    end

    // FSM next state and per-edge strobes; clear overrides everything.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load_en    = 1'b0;
        score_en   = 1'b0;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        if (!bus.clear) begin
            case (state)
                IDLE: begin
                    if (bus.deal_req) begin
                        if (target_full) begin
                            err_next = 1'b1;
                        end else begin
                            accept     = 1'b1;
                            state_next = LOAD;
                        end
                    end
                end
                LOAD: begin
                    load_en    = 1'b1;
                    state_next = SCORE;
                end
                SCORE: begin
                    score_en   = 1'b1;
                    ack_next   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else begin
            state_next = IDLE;
        end
        busy_next = (state_next == LOAD) || (state_next == SCORE);
    end

    // FSM state and registered status pulses.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_next;
            busy_r <= busy_next;
            ack_r  <= ack_next;
            err_r  <= err_next;
        end
    end

    // Latch the dealt card and its destination when a request is accepted.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            card     <= '0;
            deal_dst <= 1'b0;
        end else if (accept) begin
            card     <= deck_cnt;
            deal_dst <= bus.deal_to;
        end
    end

    // Hand slots: cleared together, written one card per LOAD.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pslot <= '0;
            dslot <= '0;
        end else if (bus.clear) begin
            pslot <= '0;
            dslot <= '0;
        end else if (load_en) begin
            if (deal_dst)
                dslot <= insert_card(dslot, card);
            else
                pslot <= insert_card(pslot, card);
        end
    end

    // Scores recomputed from the already-updated slots, one edge after LOAD.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            pscore <= '0;
            dscore <= '0;
        end else if (bus.clear) begin
            pscore <= '0;
            dscore <= '0;
        end else if (score_en) begin
            if (deal_dst)
                dscore <= hand_score(dslot);
            else
                pscore <= hand_score(pslot);
        end
    end

    assign bus.pcard1   = pslot[0];
    assign bus.pcard2   = pslot[1];
    assign bus.pcard3   = pslot[2];
    assign bus.dcard1   = dslot[0];
    assign bus.dcard2   = dslot[1];
    assign bus.dcard3   = dslot[2];
    assign bus.pscore   = pscore;
    assign bus.dscore   = dscore;
    assign bus.busy     = busy_r;
    assign bus.deal_ack = ack_r;
    assign bus.deal_err = err_r;
endmodule

// File: tb/tb_hand_dealer.sv
// Scoreboard bench for hand_dealer: stimulus queues expected ack/err snapshots,
// a negedge monitor pops and compares them whenever the DUT pulses an event.
module tb_hand_dealer;
    logic clk = 1'b0;
    logic resetb;
    hand_dealer_if bus ();

    hand_dealer dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic       ack;
        logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
    } evt_t;

    evt_t       exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] tb_deck;

    // Reference deck: 1 at reset, then 2,3,..,13,1,.. on each rising edge.
    always @(posedge clk or negedge resetb) begin
        if (!resetb)
            tb_deck <= 4'd1;
        else
            tb_deck <= (tb_deck == 4'd13) ? 4'd1 : tb_deck + 4'd1;
    end

    // Monitor: every ack/err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        evt_t got;
        evt_t e;
        if (resetb === 1'b1 && (bus.deal_ack === 1'b1 || bus.deal_err === 1'b1)) begin
            got = {bus.deal_err, bus.deal_ack, bus.pcard1, bus.pcard2, bus.pcard3,
                   bus.dcard1, bus.dcard2, bus.dcard3, bus.pscore, bus.dscore};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL event got=%h required=%h", got, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.busy, bus.deal_ack, bus.deal_err, bus.pcard1, bus.pcard2, bus.pcard3,
                   bus.dcard1, bus.dcard2, bus.dcard3, bus.pscore, bus.dscore}, 64'd0);
    endtask

    task automatic expect_evt(input logic e, input logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds);
        evt_t x;
        x = {e, ~e, p1, p2, p3, d1, d2, d3, ps, ds};
        exp_q.push_back(x);
    endtask

    task automatic wait_deck(input logic [3:0] c);
        int g;
        g = 0;
        while (tb_deck !== c && g < 30) begin
            step();
            g++;
        end
        if (g >= 30) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_deck got=%0d required=%0d", tb_deck, c);
        end
    endtask

    // Request a deal when card c is on top, then run through LOAD and SCORE.
    task automatic deal_at(input logic [3:0] c, input logic dst);
        wait_deck(c);
        bus.deal_to  = dst;
        bus.deal_req = 1'b1;
        step();
        bus.deal_req = 1'b0;
        step();
        step();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    initial begin
        int g;
        bus.deal_req = 1'b0;
        bus.deal_to  = 1'b0;
        bus.clear    = 1'b0;
        resetb       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_state");
        @(negedge clk);
        #1 resetb = 1'b1;

        // Four edges after release the top card is 5.
        repeat (4) @(posedge clk);
        #1;
        expect_evt(1'b0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0);
        bus.deal_to  = 1'b0;
        bus.deal_req = 1'b1;
        step();
        bus.deal_req = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
        chk("pcard1_before_load", bus.pcard1, 0);
        step();
        chk("pcard1_after_load", bus.pcard1, 5);
        chk("pscore_no_partial", bus.pscore, 0);
        chk("busy_in_score", bus.busy, 1);
        step();
        chk("pscore_after_score", bus.pscore, 5);
        chk("ack_after_score", bus.deal_ack, 1);
        chk("busy_done", bus.busy, 0);
        step();
        chk("ack_one_cycle", bus.deal_ack, 0);

        // Player 9, 8, K: 9 -> 17 mod 10 = 7 -> K adds 0.
        do_clear();
        chk_all_zero("clear_idle");
        expect_evt(1'b0, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd0);
        deal_at(4'd9, 1'b0);
        expect_evt(1'b0, 4'd9, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0);
        deal_at(4'd8, 1'b0);
        expect_evt(1'b0, 4'd9, 4'd8, 4'd13, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0);
        deal_at(4'd13, 1'b0);
        chk("dealer_untouched", {bus.dcard1, bus.dcard2, bus.dcard3, bus.dscore}, 0);

        // Fourth card to a full player hand is rejected.
        expect_evt(1'b1, 4'd9, 4'd8, 4'd13, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0);
        bus.deal_to  = 1'b0;
        bus.deal_req = 1'b1;
        step();
        bus.deal_req = 1'b0;
        chk("err_pulse", bus.deal_err, 1);
        chk("busy_on_err", bus.busy, 0);
        step();
        chk("err_one_cycle", bus.deal_err, 0);
        chk("full_hand_kept", {bus.pcard1, bus.pcard2, bus.pcard3, bus.pscore}, 16'h98d7);

        // Held request: dealer gets 2,5,8 (15 -> 5), then player gets J (0).
        do_clear();
        wait_deck(4'd2);
        expect_evt(1'b0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd2);
        expect_evt(1'b0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd5, 4'd0, 4'd0, 4'd7);
        expect_evt(1'b0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd5, 4'd8, 4'd0, 4'd5);
        expect_evt(1'b0, 4'd11, 4'd0, 4'd0, 4'd2, 4'd5, 4'd8, 4'd0, 4'd5);
        for (int i = 0; i < 12; i++) begin
            bus.deal_req = 1'b1;
            bus.deal_to  = (i < 9) ? 1'b1 : 1'b0;
            step();
        end
        bus.deal_req = 1'b0;
        chk("held_pcard1_jack", bus.pcard1, 11);
        chk("held_dscore_wrap", bus.dscore, 5);

        // A request raised while busy is ignored.
        expect_evt(1'b0, 4'd11, 4'd4, 4'd0, 4'd2, 4'd5, 4'd8, 4'd4, 4'd5);
        wait_deck(4'd4);
        bus.deal_to  = 1'b0;
        bus.deal_req = 1'b1;
        step();
        step();
        bus.deal_req = 1'b0;
        repeat (3) step();
        chk("busy_req_ignored", bus.pcard3, 0);

        // Clear during LOAD aborts the deal.
        wait_deck(4'd6);
        bus.deal_to  = 1'b0;
        bus.deal_req = 1'b1;
        step();
        bus.deal_req = 1'b0;
        do_clear();
        chk_all_zero("clear_in_load");
        step();
        chk_all_zero("clear_in_load_no_ack");

        // Clear together with a request: clear wins.
        expect_evt(1'b0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd3);
        deal_at(4'd3, 1'b1);
        bus.clear    = 1'b1;
        bus.deal_req = 1'b1;
        bus.deal_to  = 1'b0;
        step();
        bus.clear    = 1'b0;
        bus.deal_req = 1'b0;
        chk_all_zero("clear_with_req");
        repeat (3) step();
        chk_all_zero("clear_with_req_late");

        // Asynchronous reset pulse mid-SCORE.
        wait_deck(4'd7);
        bus.deal_to  = 1'b0;
        bus.deal_req = 1'b1;
        step();
        bus.deal_req = 1'b0;
        step();
        chk("pre_reset_slot", bus.pcard1, 7);
        #1 resetb = 1'b0;
        #1 chk_all_zero("async_reset");
        #1 resetb = 1'b1;

        // Deck restarts at 1: a request at the first edge deals an ace.
        expect_evt(1'b0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0);
        bus.deal_to  = 1'b0;
        bus.deal_req = 1'b1;
        step();
        bus.deal_req = 1'b0;
        step();
        step();
        chk("restart_ace", bus.pcard1, 1);
        expect_evt(1'b0, 4'd1, 4'd13, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0);
        deal_at(4'd13, 1'b0);
        expect_evt(1'b0, 4'd1, 4'd13, 4'd1, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0);
        deal_at(4'd1, 1'b0);

        g = 0;
        while (exp_q.size() != 0 && g < 20) begin
            step();
            g++;
        end
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
